// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator outcome tracker: FSM/run-kind encoding
// and default counter widths.
package cmp_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int RUN_W_DEF = 4;

  // The run state doubles as the run_kind output code.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_G = 2'd1,
    RUN_L = 2'd2,
    RUN_E = 2'd3
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_G    = 2'd1;
  localparam logic [1:0] KIND_L    = 2'd2;
  localparam logic [1:0] KIND_E    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc
// restarts the count at one. nxt exposes the value loaded on the next edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = q;
    if (clr)
      nxt = W'(inc);
    else if (inc && (q != '1))
      nxt = q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= '0;
    else
      q <= nxt;
  end

endmodule

// File: rtl/cmp_outcome_tracker.sv
// Outcome statistics for the magnitude comparator: saturating per-outcome
// counts, current run tracking and run alert. Optional CMP_ONEHOT_CHECK_EN.
module cmp_outcome_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RUN_W   = RUN_W_DEF,
  parameter int RUN_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             G,
  input  logic             L,
  input  logic             E,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_e,
  output logic [RUN_W-1:0] run_len,
  output logic [1:0]       run_kind,
  output logic             run_alert,
  output logic             err
);

  localparam logic [RUN_W-1:0] THR = RUN_W'(RUN_THR);

  state_t           state;
  state_t           kind;
  logic             legal;
  logic             accept;
  logic             new_run;
  logic [RUN_W-1:0] run_nxt;
  logic [CNT_W-1:0] g_nxt, l_nxt, e_nxt;
  logic             unused_nxt;

`ifdef CMP_ONEHOT_CHECK_EN
  logic bad;

  always_comb begin
    kind = IDLE;
    case ({G, L, E})
      3'b100:  kind = RUN_G;
      3'b010:  kind = RUN_L;
      3'b001:  kind = RUN_E;
      default: kind = IDLE;
    endcase
  end

  assign legal = in_valid && (kind != IDLE);
  assign bad   = in_valid && (kind == IDLE);

  // Sticky until reset; a sample dropped by clr is never inspected.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if (bad && !clr)
      err <= 1'b1;
  end
`else
  // Without checking, multi-hot samples resolve E > G > L.
  always_comb begin
    kind = IDLE;
    if (E)
      kind = RUN_E;
    else if (G)
      kind = RUN_G;
    else if (L)
      kind = RUN_L;
  end

  assign legal = in_valid && (kind != IDLE);
  assign err   = 1'b0;
`endif

  assign accept  = legal && !clr;
  assign new_run = accept && (kind != state);

  sat_counter #(.W(CNT_W)) u_cnt_g (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(accept && (kind == RUN_G)),
    .q(cnt_g), .nxt(g_nxt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_l (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(accept && (kind == RUN_L)),
    .q(cnt_l), .nxt(l_nxt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_e (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(accept && (kind == RUN_E)),
    .q(cnt_e), .nxt(e_nxt)
  );

  sat_counter #(.W(RUN_W)) u_run (
    .clk(clk), .rst_n(rst_n), .clr(clr || new_run), .inc(accept),
    .q(run_len), .nxt(run_nxt)
  );

  assign unused_nxt = ^{g_nxt, l_nxt, e_nxt};

  // Alert follows the run length being loaded, so it drops with a kind change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_alert <= 1'b0;
    end else begin
      run_alert <= (run_nxt >= THR);
      if (clr)
        state <= IDLE;
      else if (accept)
        state <= kind;
    end
  end

  assign run_kind = state;

endmodule

// File: tb/tb_cmp_outcome_tracker.sv
// Self-checking bench for cmp_outcome_tracker: directed steps plus random
// traffic against a counting reference model. Honours CMP_ONEHOT_CHECK_EN.
module tb_cmp_outcome_tracker;

  localparam int CNT_MAX = 255;
  localparam int RUN_MAX = 15;
  localparam int THR     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       G = 1'b0, L = 1'b0, E = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] cnt_g, cnt_l, cnt_e;
  logic [3:0] run_len;
  logic [1:0] run_kind;
  logic       run_alert;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model state: counts indexed G=0, L=1, E=2; kind 0 none/1 G/2 L/3 E
  int m_cnt [3];
  int m_kind, m_len, m_alert, m_err;

  cmp_outcome_tracker #(.CNT_W(8), .RUN_W(4), .RUN_THR(THR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .G(G), .L(L), .E(E),
    .clr(clr), .cnt_g(cnt_g), .cnt_l(cnt_l), .cnt_e(cnt_e),
    .run_len(run_len), .run_kind(run_kind), .run_alert(run_alert), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".cnt_g"},     int'(cnt_g),     m_cnt[0]);
    check({tag, ".cnt_l"},     int'(cnt_l),     m_cnt[1]);
    check({tag, ".cnt_e"},     int'(cnt_e),     m_cnt[2]);
    check({tag, ".run_len"},   int'(run_len),   m_len);
    check({tag, ".run_kind"},  int'(run_kind),  m_kind);
    check({tag, ".run_alert"}, int'(run_alert), m_alert);
    check({tag, ".err"},       int'(err),       m_err);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_kind = 0; m_len = 0; m_alert = 0; m_err = 0;
  endfunction

  function automatic void modelStep(input bit v, input bit g, input bit l,
                                    input bit e, input bit c);
    int k;
    int hot;
    if (c) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_kind = 0; m_len = 0;
    end else if (v) begin
      hot = int'(g) + int'(l) + int'(e);
      k = 0;
`ifdef CMP_ONEHOT_CHECK_EN
      if (hot == 1) k = g ? 1 : (l ? 2 : 3);
      else m_err = 1;
`else
      if (e) k = 3;
      else if (g) k = 1;
      else if (l) k = 2;
`endif
      if (k != 0) begin
        if (m_cnt[k-1] < CNT_MAX) m_cnt[k-1]++;
        if (k == m_kind) begin
          if (m_len < RUN_MAX) m_len++;
        end else begin
          m_kind = k;
          m_len  = 1;
        end
      end
    end
    m_alert = (m_len >= THR) ? 1 : 0;
  endfunction

  task automatic applyStimulus(input bit v, input bit g, input bit l,
                               input bit e, input bit c);
    in_valid = v; G = g; L = l; E = e; clr = c;
    @(posedge clk);
    modelStep(v, g, l, e, c);
    #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic applyCompare(input int a, input int b);
    applyStimulus(1'b1, a > b, a < b, a == b, 1'b0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    @(posedge clk);
    modelReset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit v, g, l, e, c;

    // Reset state
    applyReset();
    checkOutput("reset");
    check("reset.run_kind_idle", int'(run_kind), 0);

    // Two L outcomes from the comparator
    applyCompare(4, 5);
    checkOutput("l1");
    applyCompare(6, 8);
    checkOutput("l2");
    check("l2.cnt_l_const", int'(cnt_l), 2);
    check("l2.run_len_const", int'(run_len), 2);

    // Four E samples reach the threshold; a G breaks the run
    for (int i = 0; i < 4; i++) begin
      applyCompare(3, 3);
      checkOutput($sformatf("e%0d", i));
    end
    check("e4.alert_const", int'(run_alert), 1);
    applyCompare(9, 2);
    checkOutput("g_break");
    check("g_break.alert_const", int'(run_alert), 0);

    // Saturation of cnt_g and run_len
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 18) checkOutput("g_run_sat");
    end
    checkOutput("g_cnt_sat");
    check("g_cnt_sat.const", int'(cnt_g), 255);
    check("g_run_sat.const", int'(run_len), 15);

    // Idle cycle holds everything
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_hold");

    // clr beats a simultaneous valid sample
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_vs_valid");
    check("clr_vs_valid.cnt_g_const", int'(cnt_g), 0);

    // Non-one-hot samples
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("multi_gl");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("multi_ge");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("all_zero");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("err_after_clr");

    // Reset in the middle of a run of three
    for (int i = 0; i < 3; i++) applyCompare(1, 7);
    checkOutput("pre_reset_run");
    applyReset();
    checkOutput("mid_reset");
    applyCompare(0, 15);
    checkOutput("post_reset_l");

    // Random traffic including illegal samples and occasional clears
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) begin
        g = 1'($urandom); l = 1'($urandom); e = 1'($urandom);
      end else begin
        case ($urandom_range(0, 2))
          0:       begin g = 1; l = 0; e = 0; end
          1:       begin g = 0; l = 1; e = 0; end
          default: begin g = 0; l = 0; e = 1; end
        endcase
        if ($urandom_range(0, 1) == 0) begin
          l = g; e = 1'b0;
          if (g == 1'b0) l = 1'b1;
        end
      end
      applyStimulus(v, g, l, e, c);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
